// File: rtl/clk_gate_ctrl_if.sv
// Handshake and status bundle between the datapath units and the clock-gating controller.
// The master drives activity, requests and config; the slave returns grants and gate enables.
interface clk_gate_ctrl_if #(
  parameter int NUM_DOMAINS = 4,
  parameter int IDLE_W      = 8
);
  logic                   test_i;
  logic [IDLE_W-1:0]      cfg_idle_limit_i;
  logic [NUM_DOMAINS-1:0] cfg_force_on_i;
  logic [NUM_DOMAINS-1:0] busy_i;
  logic [NUM_DOMAINS-1:0] req_i;
  logic [NUM_DOMAINS-1:0] gnt_o;
  logic [NUM_DOMAINS-1:0] en_o;
  logic [NUM_DOMAINS-1:0] gated_o;

  modport master (
    output test_i, cfg_idle_limit_i, cfg_force_on_i, busy_i, req_i,
    input  gnt_o, en_o, gated_o
  );

  modport slave (
    input  test_i, cfg_idle_limit_i, cfg_force_on_i, busy_i, req_i,
    output gnt_o, en_o, gated_o
  );
endinterface

// File: rtl/clk_gate_ctrl.sv
// Per-domain idle-driven clock gating with RUN/OFF/WAKE FSMs; gating after the idle limit, grant
// WAKE_CYCLES edges after a wake starts. Requesters are held off (no gnt) until the domain is in RUN.
module clk_gate_ctrl #(
  parameter int NUM_DOMAINS = 4,
  parameter int IDLE_W      = 8,
  parameter int WAKE_CYCLES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  clk_gate_ctrl_if.slave   bus
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_OFF  = 2'd1;
  localparam logic [1:0] ST_WAKE = 2'd2;

  localparam logic [IDLE_W:0]   WAKE_LAST = (IDLE_W+1)'(WAKE_CYCLES);
  localparam logic [IDLE_W:0]   ONE_EXT   = (IDLE_W+1)'(1);
  localparam logic [IDLE_W-1:0] CNT_MAX   = '1;

  logic [NUM_DOMAINS-1:0][1:0]        state_q, state_d;
  logic [NUM_DOMAINS-1:0][IDLE_W-1:0] cnt_q, cnt_d;
  logic [NUM_DOMAINS-1:0][IDLE_W:0]   cnt_nxt;
  logic [NUM_DOMAINS-1:0]             act;
  logic [NUM_DOMAINS-1:0]             in_run;
  logic [NUM_DOMAINS-1:0]             in_off;

  always_comb begin
    for (int d = 0; d < NUM_DOMAINS; d++) begin
      act[d]     = bus.busy_i[d] | bus.req_i[d] | bus.cfg_force_on_i[d] | bus.test_i;
      // One bit wider so the limit compare sees cnt+1 even when cnt is saturated.
      cnt_nxt[d] = {1'b0, cnt_q[d]} + ONE_EXT;
      state_d[d] = state_q[d];
      cnt_d[d]   = cnt_q[d];
      case (state_q[d])
        ST_RUN: begin
          if (act[d]) begin
            cnt_d[d] = '0;
          end else if ((bus.cfg_idle_limit_i != '0) &&
                       (cnt_nxt[d] >= {1'b0, bus.cfg_idle_limit_i})) begin
            state_d[d] = ST_OFF;
            cnt_d[d]   = '0;
          end else if (cnt_q[d] != CNT_MAX) begin
            cnt_d[d] = cnt_nxt[d][IDLE_W-1:0];
          end
        end
        ST_OFF: begin
          if (act[d]) begin
            state_d[d] = ST_WAKE;
            cnt_d[d]   = '0;
          end
        end
        ST_WAKE: begin
          // Activity is ignored here: a started wake always runs to completion.
          if (cnt_nxt[d] == WAKE_LAST) begin
            state_d[d] = ST_RUN;
            cnt_d[d]   = '0;
          end else begin
            cnt_d[d] = cnt_nxt[d][IDLE_W-1:0];
          end
        end
        default: begin
          state_d[d] = ST_RUN;
          cnt_d[d]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= {NUM_DOMAINS{ST_RUN}};
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    for (int d = 0; d < NUM_DOMAINS; d++) begin
      in_run[d] = (state_q[d] == ST_RUN);
      in_off[d] = (state_q[d] == ST_OFF);
    end
  end

  // Enables come straight from registered state so the gate cells never see a glitch.
  assign bus.en_o    = ~in_off | {NUM_DOMAINS{bus.test_i}};
  assign bus.gated_o = in_off;
  assign bus.gnt_o   = bus.req_i & in_run;

endmodule
